ddram_arbiter: RTL
==================

# ddram_arbiter

Two-port burst arbiter that shares the single 64-bit DDRAM master port between the L2 cache (port 0) and a second burst requester such as the VGA framebuffer scanout or a disk DMA engine (port 1). It passes the winning port's command through to DDRAM and holds the grant for the whole burst. Returned read beats are steered only to the port that issued the read. It sits between `l2_cache` and the top-level DDRAM interface.

## Interface
- `ADDRBITS`, default 24. DDRAM word address is `ADDRBITS+1` bits wide (64-bit words).
- `CLK` in, 1: the single clock.
- `RESET_N` in, 1: asynchronous, active-low reset.
- `P0_ADDR` / `P1_ADDR` in, ADDRBITS+1: 64-bit word address.
- `P0_DIN` / `P1_DIN` in, 64: write data.
- `P0_BE` / `P1_BE` in, 8: byte enables.
- `P0_BURSTCNT` / `P1_BURSTCNT` in, 8: beats per burst; 0 is treated as 1.
- `P0_RD`, `P1_RD`, `P0_WE`, `P1_WE` in, 1: requests. Each is held until its BUSY is low.
- `P0_BUSY` / `P1_BUSY` out, 1: the command on that port is not accepted this cycle.
- `P0_DOUT` / `P1_DOUT` out, 64: read data, wired straight from `DDRAM_DOUT`.
- `P0_DOUT_READY` / `P1_DOUT_READY` out, 1: read beat valid for that port.
- `DDRAM_ADDR` out, ADDRBITS+1; `DDRAM_DIN` out, 64; `DDRAM_BE` out, 8; `DDRAM_BURSTCNT` out, 8; `DDRAM_RD` out, 1; `DDRAM_WE` out, 1.
- `DDRAM_DOUT` in, 64; `DDRAM_DOUT_READY` in, 1; `DDRAM_BUSY` in, 1.

## Operation
- States:
  - IDLE: no owner.
  - WBURST: write burst in progress; owner locked.
  - RWAIT: read data outstanding; owner locked.
- Registers: `state`, `owner` (1 bit), `last` (port served last, 1 bit), `beats` (8 bits).
- IDLE arbitration:
  - A port requests when RD or WE is high. If only one port requests, it wins.
  - If both request, the winner is `!last` (round-robin).
  - The winner's ADDR/DIN/BE/BURSTCNT/RD/WE are muxed combinationally onto DDRAM in the same cycle. The loser sees BUSY=1.
- Command acceptance: the winner's BUSY equals `DDRAM_BUSY`. The command is accepted on a cycle where the winner's request is high and `DDRAM_BUSY` is low. On acceptance, `owner` and `last` are set to the winner.
- Read accepted: go to RWAIT with `beats` = max(BURSTCNT,1).
- Write accepted:
  - If BURSTCNT ≤ 1, stay in IDLE.
  - Otherwise go to WBURST with `beats` = BURSTCNT−1.
- WBURST:
  - Only the owner is muxed to DDRAM. The non-owner's BUSY is 1.
  - Each owner WE accepted while `DDRAM_BUSY`=0 decrements `beats`. When `beats` reaches 0, go to IDLE.
  - RD from the owner is ignored until the burst completes.
- RWAIT:
  - DDRAM RD/WE are 0. BUSY is 1 to both ports.
  - Each `DDRAM_DOUT_READY` pulses the owner's DOUT_READY and decrements `beats`. On the last beat, go to IDLE.
- `DDRAM_DOUT_READY` in IDLE or WBURST is a stray beat: dropped, no DOUT_READY to either port.
- RD and WE both high on one port: treated as RD.
- Outputs when no port is granted: DDRAM_RD, DDRAM_WE and both DOUT_READY are 0. DDRAM_ADDR/DIN/BE/BURSTCNT show port 0's inputs.

## Timing
- Reset (RESET_N low, asynchronous):
  - State values: `state`=IDLE, `owner`=0, `last`=1 (port 0 wins the first tie), `beats`=0.
  - While RESET_N is low, both BUSY are 1 and DDRAM_RD/WE are 0.
- Arbitration and pass-through add 0 cycles. There is a combinational path from port inputs and `DDRAM_BUSY` to DDRAM outputs and BUSY.
- Read data latency equals the DDRAM latency; the arbiter adds nothing.
- The IDLE return after the last read beat is registered. A new command is first accepted one cycle after the final DOUT_READY.
- A write with BURSTCNT ≤ 1 leaves the arbiter in IDLE, so back-to-back single writes can be accepted every cycle. They alternate between ports under contention.
- Reset mid-burst: the arbiter returns to IDLE immediately. Outstanding DDRAM read beats that arrive afterwards are stray and are dropped.
- `beats` never underflows. Decrement occurs only when `beats` ≥ 1, and the state leaves at 1→0.

## Structure
- Shared package `ddram_arb_pkg`:
  - State enum (IDLE, WBURST, RWAIT).
  - Port index constants `PORT_L2=0`, `PORT_AUX=1`.
  - Beat counter width constant (8).
- Sub-module `ddram_rr_pick`: 2-way combinational round-robin pick, inputs `req[1:0]` and `last`, output `grant`. It is reused if the arbiter is later widened.

## Test plan
- Single read, P0 RD, BURSTCNT=8, addr 0x100 -> DDRAM_RD=1 for one cycle. Eight P0_DOUT_READY pulses, P1_DOUT_READY stays 0, then IDLE.
- Simultaneous P0 RD and P1 RD, both BURSTCNT=8, right after reset -> P0 granted first. P1 is accepted one cycle after P0's 8th beat. Then a second tie grants P0 again (round-robin, since `last`=1).
- P1 WE, BURSTCNT=4, with DDRAM_BUSY high on beat 2 for 3 cycles -> all 4 beats reach DDRAM in order. P0 RD held throughout sees P0_BUSY=1 until the burst completes.
- Alternating single writes, both ports WE every cycle, BURSTCNT=1, DDRAM_BUSY=0 -> accepted port sequence is 0,1,0,1…
- Stray DDRAM_DOUT_READY in IDLE -> no DOUT_READY on either port, state unchanged.
- RESET_N low after 3 of 8 read beats -> BUSY=1 on both ports immediately. The remaining beats are dropped, and a new P1 RD after reset release is accepted.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared definitions for the two-port DDRAM burst arbiter.
package ddram_arb_pkg;

  localparam int PORT_L2  = 0;
  localparam int PORT_AUX = 1;
  localparam int BEAT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RWAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ddram_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie (or no request)
// the port that was not served last wins.
module ddram_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Combinational pick, tie goes to the port that was not served last.
  always_comb begin
    grant = ~last;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/ddram_arbiter.sv
// Shares the DDRAM master port between the L2 cache (port 0) and an auxiliary
// burst requester (port 1). The grant is held for a full write burst or until
// every beat of an accepted read has come back.
//
// Handshake: a port presents RD or WE and holds its command; the command is
// taken on the cycle its BUSY is low. Read beats are signalled by a one-cycle
// DOUT_READY pulse on the port that issued the read.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int ADDRBITS = 24
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDRBITS:0] P0_ADDR,
  input  logic [63:0]       P0_DIN,
  input  logic [7:0]        P0_BE,
  input  logic [BEAT_W-1:0] P0_BURSTCNT,
  input  logic              P0_RD,
  input  logic              P0_WE,
  output logic              P0_BUSY,
  output logic [63:0]       P0_DOUT,
  output logic              P0_DOUT_READY,
  input  logic [ADDRBITS:0] P1_ADDR,
  input  logic [63:0]       P1_DIN,
  input  logic [7:0]        P1_BE,
  input  logic [BEAT_W-1:0] P1_BURSTCNT,
  input  logic              P1_RD,
  input  logic              P1_WE,
  output logic              P1_BUSY,
  output logic [63:0]       P1_DOUT,
  output logic              P1_DOUT_READY,
  output logic [ADDRBITS:0] DDRAM_ADDR,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic [BEAT_W-1:0] DDRAM_BURSTCNT,
  output logic              DDRAM_RD,
  output logic              DDRAM_WE,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  input  logic              DDRAM_BUSY,
  output arb_state_t        o_dbg_state
);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last;
  logic [BEAT_W-1:0] r_beats;

  logic [1:0]        w_req;
  logic              w_pick;
  logic              w_sel;
  logic              w_granted;
  logic              w_sel_rd;
  logic              w_sel_we;
  logic [BEAT_W-1:0] w_sel_bc;
  logic [BEAT_W-1:0] w_bc_eff;
  logic              w_cmd_rd;
  logic              w_cmd_we;
  logic              w_go;
  logic              w_accept;
  logic              w_beat;

  assign w_req = {P1_RD | P1_WE, P0_RD | P0_WE};

  ddram_rr_pick u_pick (
    .req   (w_req),
    .last  (r_last),
    .grant (w_pick)
  );

  // Which port drives the DDRAM command lines: the arbitration winner in
  // IDLE, the locked owner otherwise; port 0 when nobody is granted.
  always_comb begin
    w_sel     = 1'b0;
    w_granted = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_sel     = w_pick;
          w_granted = 1'b1;
        end
      end
      WBURST, RWAIT: begin
        w_sel     = r_owner;
        w_granted = 1'b1;
      end
      default: begin
        w_sel     = 1'b0;
        w_granted = 1'b0;
      end
    endcase
  end

  assign w_sel_rd = w_sel ? P1_RD : P0_RD;
  assign w_sel_we = w_sel ? P1_WE : P0_WE;
  assign w_sel_bc = w_sel ? P1_BURSTCNT : P0_BURSTCNT;
  assign w_bc_eff = (w_sel_bc == '0) ? BEAT_W'(1) : w_sel_bc;

  // RD wins over WE when both are high; inside a write burst only WE counts.
  assign w_cmd_rd = RESET_N & (r_state == IDLE) & w_granted & w_sel_rd;
  assign w_cmd_we = RESET_N & (((r_state == IDLE) & w_granted & ~w_sel_rd & w_sel_we) |
                               ((r_state == WBURST) & w_sel_we));
  assign w_go     = w_cmd_rd | w_cmd_we;
  assign w_accept = w_go & ~DDRAM_BUSY;
  assign w_beat   = RESET_N & (r_state == RWAIT) & DDRAM_DOUT_READY;

  assign DDRAM_ADDR     = w_sel ? P1_ADDR : P0_ADDR;
  assign DDRAM_DIN      = w_sel ? P1_DIN  : P0_DIN;
  assign DDRAM_BE       = w_sel ? P1_BE   : P0_BE;
  assign DDRAM_BURSTCNT = w_sel_bc;
  assign DDRAM_RD       = w_cmd_rd;
  assign DDRAM_WE       = w_cmd_we;

  assign P0_BUSY = ~(w_go & ~w_sel) | DDRAM_BUSY;
  assign P1_BUSY = ~(w_go &  w_sel) | DDRAM_BUSY;

  assign P0_DOUT       = DDRAM_DOUT;
  assign P1_DOUT       = DDRAM_DOUT;
  assign P0_DOUT_READY = w_beat & ~r_owner;
  assign P1_DOUT_READY = w_beat &  r_owner;

  assign o_dbg_state = r_state;

  // Arbitration FSM: lock the owner on acceptance, count burst beats down and
  // release at 1 -> 0 so the counter can never wrap.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_sel;
            r_last  <= w_sel;
            if (w_cmd_rd) begin
              r_state <= RWAIT;
              r_beats <= w_bc_eff;
            end else if (w_sel_bc > BEAT_W'(1)) begin
              r_state <= WBURST;
              r_beats <= w_sel_bc - BEAT_W'(1);
            end
          end
        end
        WBURST: begin
          if (w_accept && (r_beats != '0)) begin
            r_beats <= r_beats - BEAT_W'(1);
            if (r_beats == BEAT_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        RWAIT: begin
          if (w_beat && (r_beats != '0)) begin
            r_beats <= r_beats - BEAT_W'(1);
            if (r_beats == BEAT_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
